// File: rtl/keypad_entry.sv
// keypad_entry: keypad front end for the microwave controller.
// Decodes a one-hot key bus and debounces presses and releases. Each accepted
// digit is pulsed on pgt_1Hz and shifted into a multi-digit entry register.
// In count mode (en=0), pgt_1Hz instead carries a divided tick.
// Optional build macro KEYPAD_ENTRY_REPEAT_EN: a held key re-accepts every
// REPEAT_CYCLES cycles.
module keypad_entry #(
   parameter int NKEYS         = 10,
   parameter int DEB_CYCLES    = 4,
   parameter int DIV           = 100,
   parameter int NDIGITS       = 4,
   parameter int REPEAT_CYCLES = 50
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NKEYS-1:0]             keys,
   input  logic                         en,
   input  logic                         clr,
   output logic [3:0]                   digit,
   output logic                         key_held,
   output logic                         pgt_1Hz,
   output logic [4*NDIGITS-1:0]         entry,
   output logic [$clog2(NDIGITS+1)-1:0] ndig
);

   localparam int EW = 4 * NDIGITS;
   localparam int NW = $clog2(NDIGITS + 1);
   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam int DW = $clog2(DIV);
   localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [NW-1:0] NDIG_MAX = NW'(NDIGITS);

   if (NKEYS < 2 || NKEYS > 16 || DEB_CYCLES < 1 || DIV < 2 || NDIGITS < 1 || REPEAT_CYCLES < 1) begin : g_param_check
      $error("keypad_entry: parameter out of legal range");
   end

   typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

   state_t        state;
   logic [CW-1:0] deb_cnt;
   logic [3:0]    code_q;
   logic          accept_q;
   logic          tick_q;
   logic [DW-1:0] div_cnt;
   logic          any_key;
   logic          multi_key;
   logic          cand_vld;
   logic [3:0]    cand_code;
   logic          accept;

`ifdef KEYPAD_ENTRY_REPEAT_EN
   localparam int RW = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
   logic [RW-1:0] rep_cnt;
`endif

   // sample decode: exactly one key high gives a valid candidate, anything else is "none"
   always_comb begin
      any_key   = 1'b0;
      multi_key = 1'b0;
      cand_code = 4'd0;
      for (int i = 0; i < NKEYS; i++) begin
         if (keys[i]) begin
            multi_key = multi_key | any_key;
            any_key   = 1'b1;
            cand_code = 4'(i);
         end
      end
      cand_vld = any_key & ~multi_key;
   end

   // accept on this edge: debounce run completes, or (optionally) the repeat interval expires
   always_comb begin
      accept = 1'b0;
      if (en && cand_vld) begin
         case (state)
            IDLE:     accept = (DEB_CYCLES == 1);
            DEBOUNCE: accept = (cand_code == code_q) && (deb_cnt == DEB_LAST);
`ifdef KEYPAD_ENTRY_REPEAT_EN
            HELD:     accept = (cand_code == code_q) && (rep_cnt == REP_LAST);
`endif
            default:  accept = 1'b0;
         endcase
      end
   end

   // press/release debounce FSM with registered key_held and accept strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         deb_cnt  <= '0;
         code_q   <= 4'd0;
         key_held <= 1'b0;
         accept_q <= 1'b0;
`ifdef KEYPAD_ENTRY_REPEAT_EN
         rep_cnt  <= '0;
`endif
      end else begin
         accept_q <= accept;
         if (!en) begin
            // count mode abandons any press in progress
            state    <= IDLE;
            deb_cnt  <= '0;
            key_held <= 1'b0;
`ifdef KEYPAD_ENTRY_REPEAT_EN
            rep_cnt  <= '0;
`endif
         end else begin
            case (state)
               IDLE: begin
                  if (cand_vld) begin
                     code_q <= cand_code;
                     if (accept) begin
                        state    <= HELD;
                        key_held <= 1'b1;
                        deb_cnt  <= '0;
                     end else begin
                        state    <= DEBOUNCE;
                        deb_cnt  <= CW'(1);
                     end
                  end
               end
               DEBOUNCE: begin
                  if (cand_vld && cand_code == code_q) begin
                     if (accept) begin
                        state    <= HELD;
                        key_held <= 1'b1;
                        deb_cnt  <= '0;
                     end else begin
                        deb_cnt  <= deb_cnt + 1'b1;
                     end
                  end else begin
                     // a changed sample costs that sample: restart from IDLE next edge
                     state   <= IDLE;
                     deb_cnt <= '0;
                  end
               end
               HELD: begin
                  if (!cand_vld) begin
`ifdef KEYPAD_ENTRY_REPEAT_EN
                     rep_cnt <= '0;
`endif
                     if (DEB_CYCLES == 1) begin
                        state    <= IDLE;
                        key_held <= 1'b0;
                        deb_cnt  <= '0;
                     end else begin
                        state    <= RELEASE;
                        deb_cnt  <= CW'(1);
                     end
                  end
`ifdef KEYPAD_ENTRY_REPEAT_EN
                  else if (cand_code == code_q) begin
                     rep_cnt <= accept ? '0 : rep_cnt + 1'b1;
                  end else begin
                     rep_cnt <= '0;
                  end
`endif
               end
               RELEASE: begin
                  if (cand_vld) begin
                     state   <= HELD;
                     deb_cnt <= '0;
                  end else if (deb_cnt == DEB_LAST) begin
                     state    <= IDLE;
                     deb_cnt  <= '0;
                     key_held <= 1'b0;
                  end else begin
                     deb_cnt  <= deb_cnt + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // digit / entry shift register / digit count; clr coincident with accept keeps only the new code
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit <= 4'd0;
         entry <= '0;
         ndig  <= '0;
      end else if (accept) begin
         digit <= cand_code;
         if (clr) begin
            entry <= EW'(cand_code);
            ndig  <= NW'(1);
         end else begin
            entry <= EW'({entry, cand_code});
            if (ndig != NDIG_MAX) ndig <= ndig + 1'b1;
         end
      end else if (clr) begin
         entry <= '0;
         ndig  <= '0;
      end
   end

   // count-mode divider: runs only while en is low, pulse registered on the terminal count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         tick_q  <= 1'b0;
      end else if (en) begin
         div_cnt <= '0;
         tick_q  <= 1'b0;
      end else begin
         tick_q  <= (div_cnt == DIV_LAST);
         div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      end
   end

   // both sources are registered one-cycle pulses, so switching en cannot stretch a pulse
   assign pgt_1Hz = en ? accept_q : tick_q;

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: directed scenarios plus randomized traffic for keypad_entry,
// checked every cycle against a behavioural model of the keypad rules.
`timescale 1ns/1ps
module tb_keypad_entry;

   localparam int NK   = 10;
   localparam int DEB  = 4;
   localparam int DIVP = 8;
   localparam int ND   = 4;
   localparam int REP  = 6;
`ifdef KEYPAD_ENTRY_REPEAT_EN
   localparam int REP_ON = 1;
`else
   localparam int REP_ON = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NK-1:0] keys;
   logic          en;
   logic          clr;
   logic [3:0]    digit;
   logic          key_held;
   logic          pgt_1Hz;
   logic [4*ND-1:0] entry;
   logic [2:0]    ndig;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   keypad_entry #(
      .NKEYS(NK), .DEB_CYCLES(DEB), .DIV(DIVP), .NDIGITS(ND), .REPEAT_CYCLES(REP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .keys(keys), .en(en), .clr(clr),
      .digit(digit), .key_held(key_held), .pgt_1Hz(pgt_1Hz), .entry(entry), .ndig(ndig)
   );

   wire [24:0] obs = {digit, key_held, pgt_1Hz, entry, ndig};

   // ---------------- reference model ----------------
   int m_q[$];     // accepted digits, oldest first, at most ND kept
   bit m_held;     // a debounced key is considered down
   int m_code;     // key being debounced / held
   int m_run;      // length of current debounce run (0 = not started)
   int m_rel;      // consecutive "none" samples while held
   int m_rep;      // same-key samples since last accept while held
   bit m_acc;      // accept happened on the last edge
   bit m_tick;     // tick happened on the last edge
   int m_en0;      // consecutive edges with en low
   int m_digit;

   function automatic void model_reset();
      m_q.delete();
      m_held = 0; m_code = 0; m_run = 0; m_rel = 0; m_rep = 0;
      m_acc = 0; m_tick = 0; m_en0 = 0; m_digit = 0;
   endfunction

   function automatic int cand_of(logic [NK-1:0] k);
      if ($countones(k) != 1) return -1;
      for (int i = 0; i < NK; i++) if (k[i]) return i;
      return -1;
   endfunction

   function automatic void model_edge();
      int c;
      bit acc;
      c   = cand_of(keys);
      acc = 0;
      if (!en) begin
         m_held = 0; m_run = 0; m_rel = 0; m_rep = 0;
         m_en0++;
      end else begin
         m_en0 = 0;
         if (!m_held) begin
            if (m_run == 0) begin
               if (c >= 0) begin m_code = c; m_run = 1; end
            end else if (c == m_code) begin
               m_run++;
            end else begin
               m_run = 0;
            end
            if (m_run == DEB) begin
               acc = 1; m_held = 1; m_run = 0; m_rel = 0; m_rep = 0;
            end
         end else if (c < 0) begin
            m_rel++; m_rep = 0;
            if (m_rel == DEB) begin m_held = 0; m_rel = 0; end
         end else if (m_rel > 0) begin
            m_rel = 0; m_rep = 0;
         end else if (REP_ON != 0 && c == m_code) begin
            m_rep++;
            if (m_rep == REP) begin acc = 1; m_rep = 0; end
         end else begin
            m_rep = 0;
         end
      end
      m_tick = !en && (m_en0 % DIVP == 0);
      m_acc  = acc;
      if (clr) m_q.delete();
      if (acc) begin
         m_q.push_back(m_code);
         m_digit = m_code;
         if (m_q.size() > ND) void'(m_q.pop_front());
      end
   endfunction

   function automatic logic [24:0] expv();
      logic [15:0] e;
      e = '0;
      for (int i = 0; i < m_q.size(); i++) e = {e[11:0], 4'(m_q[i])};
      return {4'(m_digit), m_held, (en ? m_acc : m_tick), e, 3'(m_q.size())};
   endfunction

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; keys = '0; en = 1'b1; clr = 1'b0;
      #1 model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0; keys = '0; en = 1'b1; clr = 1'b0;
      #1 model_reset();
      checks++;
      if (obs !== 25'd0) begin failures++; $display("FAIL reset_initial: got %h expected %h", obs, 25'd0); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      keys = 10'd1 << 5;
      for (int i = 0; i < 2; i++) begin
         cyc();
         checks++;
         if (obs !== expv()) begin failures++; $display("FAIL reset_prep cyc=%0d: got %h expected %h", i, obs, expv()); end
      end
      #2 rst_n = 1'b0;
      #1 model_reset();
      checks++;
      if (obs !== 25'd0) begin failures++; $display("FAIL reset_mid_debounce: got %h expected %h", obs, 25'd0); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc();
         checks++;
         if (obs !== expv()) begin failures++; $display("FAIL reset_hold_prep cyc=%0d: got %h expected %h", i, obs, expv()); end
      end
      checks++;
      if (key_held !== 1'b1) begin failures++; $display("FAIL reset_hold_reached: got %b expected 1", key_held); end
      #2 rst_n = 1'b0;
      #1 model_reset();
      checks++;
      if (obs !== 25'd0) begin failures++; $display("FAIL reset_mid_hold: got %h expected %h", obs, 25'd0); end
      keys = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc();
         checks++;
         if (pgt_1Hz !== 1'b0 || obs !== expv()) begin
            failures++; $display("FAIL reset_release cyc=%0d: got %h expected %h", i, obs, expv());
         end
      end
   endtask

   task automatic test_single_press();
      int pulses;
      int pulse_at;
      pulses = 0; pulse_at = -1;
      apply_reset();
      keys = 10'd1 << 7;
      for (int i = 1; i <= 10; i++) begin
         cyc();
         if (pgt_1Hz) begin pulses++; if (pulse_at < 0) pulse_at = i; end
         checks++;
         if (obs !== expv()) begin failures++; $display("FAIL single_press cyc=%0d: got %h expected %h", i, obs, expv()); end
      end
      keys = '0;
      for (int i = 1; i <= 8; i++) begin
         cyc();
         if (pgt_1Hz) pulses++;
         checks++;
         if (obs !== expv()) begin failures++; $display("FAIL single_release cyc=%0d: got %h expected %h", i, obs, expv()); end
      end
      checks++;
      if (pulses !== 1 + REP_ON || pulse_at !== DEB) begin
         failures++; $display("FAIL single_pulses: got count=%0d first=%0d expected count=%0d first=%0d", pulses, pulse_at, 1 + REP_ON, DEB);
      end
      checks++;
      if (digit !== 4'd7 || entry !== (REP_ON != 0 ? 16'h0077 : 16'h0007) || ndig !== 3'(1 + REP_ON) || key_held !== 1'b0) begin
         failures++; $display("FAIL single_state: got digit=%h entry=%h ndig=%0d held=%b", digit, entry, ndig, key_held);
      end
   endtask

   task automatic test_bounce();
      int pulses;
      int pulse_at;
      pulses = 0; pulse_at = -1;
      apply_reset();
      for (int i = 1; i <= 14; i++) begin
         keys = (i <= 3 || (i >= 5 && i <= 8)) ? (10'd1 << 3) : '0;
         cyc();
         if (pgt_1Hz) begin pulses++; if (pulse_at < 0) pulse_at = i; end
         checks++;
         if (obs !== expv()) begin failures++; $display("FAIL bounce cyc=%0d: got %h expected %h", i, obs, expv()); end
      end
      checks++;
      if (pulses !== 1 || pulse_at !== 8) begin
         failures++; $display("FAIL bounce_pulses: got count=%0d at=%0d expected count=1 at=8", pulses, pulse_at);
      end
   endtask

   task automatic test_sequence();
      apply_reset();
      for (int d = 1; d <= 5; d++) begin
         for (int i = 0; i < 10; i++) begin
            keys = (i < 5) ? (10'd1 << d) : '0;
            cyc();
            checks++;
            if (obs !== expv()) begin failures++; $display("FAIL sequence d=%0d cyc=%0d: got %h expected %h", d, i, obs, expv()); end
         end
      end
      checks++;
      if (entry !== 16'h2345 || ndig !== 3'd4) begin
         failures++; $display("FAIL sequence_entry: got entry=%h ndig=%0d expected entry=2345 ndig=4", entry, ndig);
      end
      keys = 10'd1 << 9;
      for (int i = 1; i <= 4; i++) begin
         clr = (i == 4);
         cyc();
         checks++;
         if (obs !== expv()) begin failures++; $display("FAIL clr_accept cyc=%0d: got %h expected %h", i, obs, expv()); end
      end
      clr = 1'b0;
      checks++;
      if (entry !== 16'h0009 || ndig !== 3'd1 || digit !== 4'd9 || pgt_1Hz !== 1'b1) begin
         failures++; $display("FAIL clr_accept_state: got entry=%h ndig=%0d digit=%h pgt=%b expected 0009 1 9 1", entry, ndig, digit, pgt_1Hz);
      end
      keys = '0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         checks++;
         if (obs !== expv()) begin failures++; $display("FAIL clr_release cyc=%0d: got %h expected %h", i, obs, expv()); end
      end
   endtask

   task automatic test_multi_key();
      int pulses;
      pulses = 0;
      keys = (10'd1 << 2) | (10'd1 << 5);
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (pgt_1Hz) pulses++;
         checks++;
         if (obs !== expv()) begin failures++; $display("FAIL multi_key cyc=%0d: got %h expected %h", i, obs, expv()); end
      end
      checks++;
      if (pulses !== 0 || key_held !== 1'b0) begin
         failures++; $display("FAIL multi_key_none: got pulses=%0d held=%b expected 0 0", pulses, key_held);
      end
   endtask

   task automatic test_count_mode();
      keys = '0;
      en   = 1'b0;
      for (int i = 1; i <= 30; i++) begin
         cyc();
         checks++;
         if (pgt_1Hz !== (i % DIVP == 0) || obs !== expv()) begin
            failures++; $display("FAIL count_tick cyc=%0d: got %h pgt=%b expected %h", i, obs, pgt_1Hz, expv());
         end
         if (i == 3) keys = 10'd1 << 6;
      end
      en = 1'b1;
      for (int j = 1; j <= 6; j++) begin
         cyc();
         checks++;
         if (pgt_1Hz !== (j == DEB) || obs !== expv()) begin
            failures++; $display("FAIL en_rise_accept cyc=%0d: got %h pgt=%b expected %h", j, obs, pgt_1Hz, expv());
         end
      end
      keys = '0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         checks++;
         if (obs !== expv()) begin failures++; $display("FAIL en_rise_release cyc=%0d: got %h expected %h", i, obs, expv()); end
      end
   endtask

   task automatic test_repeat();
      int pulses;
      pulses = 0;
      apply_reset();
      keys = 10'd1 << 4;
      for (int i = 1; i <= DEB + 20; i++) begin
         cyc();
         if (pgt_1Hz) pulses++;
         checks++;
         if (obs !== expv()) begin failures++; $display("FAIL repeat cyc=%0d: got %h expected %h", i, obs, expv()); end
      end
      checks++;
      if (pulses !== (REP_ON != 0 ? 4 : 1)) begin
         failures++; $display("FAIL repeat_count: got %0d expected %0d", pulses, (REP_ON != 0 ? 4 : 1));
      end
      keys = '0;
      for (int i = 0; i < 6; i++) cyc();
   endtask

   task automatic test_random();
      int left;
      int r;
      int k1;
      int k2;
      left = 0;
      for (int i = 0; i < 3000; i++) begin
         if (left == 0) begin
            r  = $urandom_range(0, 9);
            k1 = $urandom_range(0, NK - 1);
            if (r < 5) keys = 10'd1 << k1;
            else if (r < 7) keys = '0;
            else if (r < 8) begin
               k2 = (k1 + 1 + $urandom_range(0, NK - 2)) % NK;
               keys = (10'd1 << k1) | (10'd1 << k2);
            end else keys = 10'($urandom);
            left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 14);
         end
         left--;
         if ($urandom_range(0, 59) == 0) en = ~en;
         clr = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 599) == 0) begin
            #2 rst_n = 1'b0;
            #1 model_reset();
            checks++;
            if (obs !== 25'd0) begin failures++; $display("FAIL random_reset i=%0d: got %h expected 0", i, obs); end
            @(posedge clk);
            #1 rst_n = 1'b1;
         end
         cyc();
         checks++;
         if (obs !== expv()) begin
            failures++; $display("FAIL random cyc=%0d keys=%h en=%b clr=%b: got %h expected %h", i, keys, en, clr, obs, expv());
         end
      end
      en = 1'b1; clr = 1'b0; keys = '0;
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_press();
      test_bounce();
      test_sequence();
      test_multi_key();
      test_count_mode();
      test_repeat();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Parametrised keypad front end for the microwave controller. Converts a one-hot-per-key input bus into a debounced 4-bit digit code with a single-cycle accept strobe and a multi-digit entry shift register. In count mode it supplies a divided tick to the same strobe output. Sits between the keypad pins and the timer/display datapath, replacing the combinational encoder/debouncer/divider group.

## Interface
- NKEYS, 10: number of keys; key i encodes digit i; legal range 2..16.
- DEB_CYCLES, 4: consecutive stable cycles needed to accept a press or a release; ≥1.
- DIV, 100: clock cycles per tick in count mode; ≥2.
- NDIGITS, 4: digits held in the entry register; ≥1.
- REPEAT_CYCLES, 50: auto-repeat interval; used only with the repeat macro.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- keys  in  NKEYS  raw key levels, active high, asynchronous to nothing (already synchronised upstream).
- en  in  1  1 = entry mode (keys accepted), 0 = count mode (tick output).
- clr  in  1  synchronous clear of entry and ndig.
- digit  out  4  last accepted digit.
- key_held  out  1  high while a debounced key is held.
- pgt_1Hz  out  1  en ? accept strobe : tick; one-cycle pulses.
- entry  out  4*NDIGITS  accepted digits, newest in bits [3:0].
- ndig  out  $clog2(NDIGITS+1)  digits held, saturates at NDIGITS.

## Operation
- Sample decode: exactly one key high → valid candidate with code = its index; zero keys or two-plus keys → "none".
- FSM states: IDLE, DEBOUNCE, HELD, RELEASE.
- IDLE: candidate valid and en=1 → DEBOUNCE, debounce counter = 1, candidate latched.
- DEBOUNCE: same candidate → counter+1; counter reaching DEB_CYCLES → accept, go HELD. Different candidate or none → IDLE, counter cleared.
- Accept: digit ← code; entry ← {entry[4*NDIGITS-5:0], code}; ndig ← min(ndig+1, NDIGITS); accept strobe high one cycle.
- HELD: key_held=1; candidate none for a cycle → RELEASE, counter = 1.
- RELEASE: none for DEB_CYCLES consecutive cycles → IDLE; any key present → HELD, counter cleared. No new accept until return to IDLE.
- en=0 forces FSM to IDLE from any state; no accept strobe issued; entry/ndig retained.
- clr: entry and ndig zeroed. clr coincident with accept → entry = {0…, code}, ndig = 1.
- Tick divider: counter runs 0..DIV-1 only while en=0, tick high on the cycle counter = DIV-1, then wraps to 0. en=1 holds counter at 0.

## Timing
- Reset values: digit=0, key_held=0, pgt_1Hz=0, entry=0, ndig=0, FSM IDLE, all counters 0.
- Press latency: single key stable at edges 1..DEB_CYCLES → accept strobe, digit, entry, ndig updated on edge DEB_CYCLES; pgt_1Hz high for the following cycle only.
- Key held at en rising edge is debounced from the first edge with en=1 and accepted normally.
- Tick: first tick DIV cycles after en falls; period exactly DIV cycles.
- pgt_1Hz is registered-pulse muxed by en; en toggling cannot create a pulse longer than one cycle.
- rst_n assertion mid-debounce or mid-hold returns everything to reset values immediately; no strobe on deassertion.

## Configuration
- KEYPAD_ENTRY_REPEAT_EN defined: in HELD, after REPEAT_CYCLES cycles with the same key, re-accept the key (strobe, shift, ndig update) and repeat every REPEAT_CYCLES while held; repeat counter clears on leaving HELD.
- Undefined: one accept per press; REPEAT_CYCLES ignored, no repeat counter synthesised.

## Test plan
- Reset: rst_n low mid-operation → all outputs 0 immediately, FSM IDLE.
- DEB_CYCLES=4, en=1, key 7 held 10 cycles → one pgt_1Hz pulse after 4th edge, digit=7, entry=0x0007, ndig=1, key_held high until release debounced.
- Bounce: key 3 for 3 cycles, off 1, on 4 cycles → exactly one accept, after the second run.
- Keys 1,2,3,4,5 (NDIGITS=4) → entry=0x2345, ndig=4; then clr with key 9 accept same cycle → entry=0x0009, ndig=1.
- Keys 2 and 5 together for 10 cycles → no accept; en=0, DIV=8 → pgt_1Hz pulses every 8 cycles, first 8 cycles after en falls, key presses ignored.
- With KEYPAD_ENTRY_REPEAT_EN, REPEAT_CYCLES=6, key 4 held 20 cycles after accept → repeats at +6, +12, +18; without macro → single accept.
